// File: rtl/wide_port_assembler.sv
// Assembles CHUNK_W-bit chunks LSB-first into one WIDTH-bit word behind valid/ready handshakes.
// Optional macro WIDE_PORT_ASSEMBLER_PARITY_EN adds wide_parity, the XOR of all wide_data bits.
module wide_port_assembler #(
  parameter int unsigned WIDTH   = 8888,
  parameter int unsigned CHUNK_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               chunk_valid,
  output logic               chunk_ready,
  input  logic [CHUNK_W-1:0] chunk_data,
  input  logic               chunk_last,
  output logic               wide_valid,
  input  logic               wide_ready,
  output logic [WIDTH-1:0]   wide_data,
  output logic               wide_short,
`ifdef WIDE_PORT_ASSEMBLER_PARITY_EN
  output logic               wide_parity,
`endif
  output logic               len_err,
  output logic [15:0]        word_count
);

  localparam int unsigned NCHUNK = (WIDTH + CHUNK_W - 1) / CHUNK_W;
  localparam int unsigned IDX_W  = $clog2(NCHUNK);
  localparam int unsigned TOP_W  = WIDTH - (NCHUNK - 1) * CHUNK_W;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic             accept_c;
  logic             close_c;
  logic             release_c;
  logic             ready_next;
  logic             valid_next;

  assign accept_c  = chunk_valid & chunk_ready & (state == FILL);
  assign close_c   = accept_c & (chunk_last | (idx == TOP_IDX));
  assign release_c = (state == HOLD) & wide_ready;

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      chunk_ready <= 1'b0;
      wide_valid  <= 1'b0;
    end else begin
      state       <= state_next;
      chunk_ready <= ready_next;
      wide_valid  <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (close_c)   state_next = HOLD;
      HOLD:    if (release_c) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    ready_next = 1'b0;
    valid_next = 1'b0;
    if (state_next == FILL) ready_next = 1'b1;
    else                    valid_next = 1'b1;
  end

  // Slot write, status flags and the completed-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wide_data  <= '0;
      idx        <= '0;
      wide_short <= 1'b0;
      len_err    <= 1'b0;
      word_count <= '0;
    end else if (release_c) begin
      wide_data  <= '0;
      idx        <= '0;
      wide_short <= 1'b0;
      word_count <= word_count + 16'd1;
    end else if (accept_c) begin
      for (int i = 0; i < int'(NCHUNK) - 1; i++) begin
        if (idx == IDX_W'(i)) wide_data[i*CHUNK_W +: CHUNK_W] <= chunk_data;
      end
      // Top slot is narrower than a chunk; the excess chunk bits are dropped.
      if (idx == TOP_IDX) wide_data[WIDTH-1 -: TOP_W] <= chunk_data[TOP_W-1:0];
      idx <= idx + IDX_W'(1);
      if (chunk_last && (idx != TOP_IDX)) wide_short <= 1'b1;
      if (!chunk_last && (idx == TOP_IDX)) len_err <= 1'b1;
    end
  end

`ifdef WIDE_PORT_ASSEMBLER_PARITY_EN
  logic chunk_par_c;

  assign chunk_par_c = (idx == TOP_IDX) ? ^chunk_data[TOP_W-1:0] : ^chunk_data;

  // Running parity folded in per accepted chunk, cleared with the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wide_parity <= 1'b0;
    else if (release_c) wide_parity <= 1'b0;
    else if (accept_c)  wide_parity <= wide_parity ^ chunk_par_c;
  end
`endif

endmodule

// File: tb/tb_wide_port_assembler.sv
// Scoreboard bench for wide_port_assembler: a chunk-level model queues expected words,
// which are popped and compared when the assembler presents them.
module tb_wide_port_assembler;

  localparam int unsigned WIDTH   = 8888;
  localparam int unsigned CHUNK_W = 64;
  localparam int unsigned NCHUNK  = 139;
  localparam int unsigned TOP_W   = 56;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               chunk_valid;
  logic               chunk_ready;
  logic [CHUNK_W-1:0] chunk_data;
  logic               chunk_last;
  logic               wide_valid;
  logic               wide_ready;
  logic [WIDTH-1:0]   wide_data;
  logic               wide_short;
  logic               len_err;
  logic [15:0]        word_count;
`ifdef WIDE_PORT_ASSEMBLER_PARITY_EN
  logic               wide_parity;
`endif

  wide_port_assembler #(.WIDTH(WIDTH), .CHUNK_W(CHUNK_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .chunk_data  (chunk_data),
    .chunk_last  (chunk_last),
    .wide_valid  (wide_valid),
    .wide_ready  (wide_ready),
    .wide_data   (wide_data),
    .wide_short  (wide_short),
`ifdef WIDE_PORT_ASSEMBLER_PARITY_EN
    .wide_parity (wide_parity),
`endif
    .len_err     (len_err),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             short_f;
    logic             len_err;
    logic [15:0]      count;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] m_buf;
  int               m_idx;
  logic             m_len_err;
  logic [15:0]      m_count;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_buf     = '0;
    m_idx     = 0;
    m_len_err = 1'b0;
    m_count   = '0;
    sb_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_chunk(input logic [63:0] d, input logic l);
    int guard = 0;
    chunk_valid = 1'b1;
    chunk_data  = d;
    chunk_last  = l;
    while (chunk_ready !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        check("chunk_ready_timeout", 64'(chunk_ready), 64'd1);
        chunk_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    chunk_valid = 1'b0;
    if (m_idx < int'(NCHUNK) - 1) m_buf[m_idx*CHUNK_W +: CHUNK_W] = d;
    else                          m_buf[WIDTH-1 -: TOP_W] = d[TOP_W-1:0];
    if (!l && m_idx == int'(NCHUNK) - 1) m_len_err = 1'b1;
    if (l || m_idx == int'(NCHUNK) - 1) begin
      m_count++;
      sb_q.push_back('{m_buf, (m_idx < int'(NCHUNK) - 1), m_len_err, m_count});
      m_buf = '0;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // mode 0: data = chunk index; 1: random; 2: random with all-ones final chunk.
  task automatic send_word(input int n, input int mode, input logic last_on_final);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       d = 64'(i);
        1:       d = {$urandom, $urandom};
        default: d = (i == n - 1) ? '1 : {$urandom, $urandom};
      endcase
      send_chunk(d, last_on_final && (i == n - 1));
    end
  endtask

  task automatic consume(input int hold, input logic offer, input logic [63:0] od);
    exp_t e;
    check("wide_valid_latency", 64'(wide_valid), 64'd1);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    if (offer) begin
      chunk_valid = 1'b1;
      chunk_data  = od;
      chunk_last  = 1'b0;
    end
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check("bp_chunk_ready", 64'(chunk_ready), 64'd0);
      check("bp_wide_valid", 64'(wide_valid), 64'd1);
      check("bp_data0", wide_data[63:0], e.data[63:0]);
    end
    for (int k = 0; k < int'(NCHUNK) - 1; k++)
      check($sformatf("data_slot%0d", k), wide_data[k*CHUNK_W +: CHUNK_W],
            e.data[k*CHUNK_W +: CHUNK_W]);
    check("data_top", 64'(wide_data[WIDTH-1 -: TOP_W]), 64'(e.data[WIDTH-1 -: TOP_W]));
    check("wide_short", 64'(wide_short), 64'(e.short_f));
    check("len_err", 64'(len_err), 64'(e.len_err));
`ifdef WIDE_PORT_ASSEMBLER_PARITY_EN
    check("wide_parity", 64'(wide_parity), 64'(^e.data));
`endif
    wide_ready = 1'b1;
    @(negedge clk);
    wide_ready = 1'b0;
    check("post_wide_valid", 64'(wide_valid), 64'd0);
    check("post_chunk_ready", 64'(chunk_ready), 64'd1);
    check("post_word_count", 64'(word_count), 64'(e.count));
    check("post_wide_short", 64'(wide_short), 64'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_chunk_ready"}, 64'(chunk_ready), 64'd0);
    check({pfx, "_wide_valid"}, 64'(wide_valid), 64'd0);
    check({pfx, "_wide_short"}, 64'(wide_short), 64'd0);
    check({pfx, "_len_err"}, 64'(len_err), 64'd0);
    check({pfx, "_word_count"}, 64'(word_count), 64'd0);
    check({pfx, "_data_zero"}, 64'(wide_data != '0), 64'd0);
`ifdef WIDE_PORT_ASSEMBLER_PARITY_EN
    check({pfx, "_wide_parity"}, 64'(wide_parity), 64'd0);
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    chunk_valid = 1'b0;
    chunk_data  = '0;
    chunk_last  = 1'b0;
    wide_ready  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    check("release_chunk_ready", 64'(chunk_ready), 64'd0);
    @(negedge clk);
    check("first_edge_chunk_ready", 64'(chunk_ready), 64'd1);

    // Full word with data = index, last on the final chunk.
    send_word(139, 0, 1'b1);
    check("full_low_chunk", wide_data[63:0], 64'd0);
    check("full_top_slot", 64'(wide_data[WIDTH-1 -: TOP_W]), 64'h8A);
    // Backpressure for 20 cycles while the next word's first chunk is offered.
    consume(20, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA);

    // Short word starting from a cleared buffer at slot 0.
    send_chunk(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    send_chunk(64'h5555_5555_5555_5555, 1'b0);
    send_chunk(64'h0000_0000_0000_1234, 1'b1);
    check("short_flag", 64'(wide_short), 64'd1);
    check("short_slot3_zero", wide_data[255:192], 64'd0);
    consume(0, 1'b0, '0);

    // Missing last with an all-ones final chunk exercises truncation and len_err.
    send_word(139, 2, 1'b0);
    check("trunc_top_slot", 64'(wide_data[WIDTH-1 -: TOP_W]), 64'h00FF_FFFF_FFFF_FFFF);
    check("missing_last_len_err", 64'(len_err), 64'd1);
    consume(3, 1'b0, '0);

    // Good word afterwards: len_err remains sticky.
    send_word(139, 1, 1'b1);
    consume(0, 1'b0, '0);
    check("len_err_sticky", 64'(len_err), 64'd1);

    // Reset in the middle of a word.
    send_word(50, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_ready_back", 64'(chunk_ready), 64'd1);
    send_word(139, 1, 1'b1);
    consume(2, 1'b0, '0);
    send_word(7, 1, 1'b1);
    consume(0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
